// File: rtl/int_vector_sequencer.sv
// Interrupt / BRK / reset vector sequencer: arbitrates NUM_SRC edge or level sources and
// walks the six-step push and vector-fetch sequence, producing the full 16-bit vector address.
module int_vector_sequencer #(
  parameter int                 NUM_SRC   = 4,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = 4'b0001,
  parameter logic [15:0]        VEC_BASE  = 16'hFFE0,
  parameter logic [15:0]        BRK_VEC   = 16'hFFFE,
  parameter logic [15:0]        RES_VEC   = 16'hFFFC,
  localparam int                SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               CLK,
  input  logic               n_RES,
  input  logic               RDY,
  input  logic               T0,
  input  logic               BRK_OP,
  input  logic               I_FLAG,
  input  logic [NUM_SRC-1:0] IRQ_REQ,
  output logic               SEQ_ACTIVE,
  output logic [2:0]         SEQ_STEP,
  output logic               PUSH_EN,
  output logic               B_OUT,
  output logic [15:0]        VEC_ADDR,
  output logic               VEC_VALID,
  output logic               SET_I,
  output logic [SRC_W-1:0]   SRC_ID,
  output logic [NUM_SRC-1:0] ACK
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_2    = 3'd2,
    S_3    = 3'd3,
    S_4    = 3'd4,
    S_5    = 3'd5,
    S_6    = 3'd6
  } step_e;

  typedef enum logic [1:0] {
    K_RES = 2'd0,
    K_HW  = 2'd1,
    K_BRK = 2'd2
  } kind_e;

  step_e              step_q, step_d;
  kind_e              kind_q, kind_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic               b_q, b_d;
  logic               resPend_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] hist_q;

  logic [NUM_SRC-1:0] edgePend;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] ack;
  logic               reqAny, edgeAny;
  logic [SRC_W-1:0]   reqIdx, edgeIdx;
  logic               hijack;
  logic               active;
  logic [15:0]        vecBase;

  // History resets to all ones so a line already high at reset release never counts as an edge.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      step_q    <= S_IDLE;
      kind_q    <= K_RES;
      src_q     <= '0;
      b_q       <= 1'b0;
      resPend_q <= 1'b1;
      pend_q    <= '0;
      hist_q    <= '1;
    end else begin
      step_q    <= step_d;
      kind_q    <= kind_d;
      src_q     <= src_d;
      b_q       <= b_d;
      resPend_q <= 1'b0;
      pend_q    <= pend_d;
      hist_q    <= IRQ_REQ;
    end
  end

  assign edgePend = pend_q & EDGE_MASK;
  assign req      = edgePend | (IRQ_REQ & ~EDGE_MASK & {NUM_SRC{~I_FLAG}});

  always_comb begin
    reqAny  = 1'b0;
    reqIdx  = '0;
    edgeAny = 1'b0;
    edgeIdx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        reqAny = 1'b1;
        reqIdx = SRC_W'(i);
      end
      if (edgePend[i]) begin
        edgeAny = 1'b1;
        edgeIdx = SRC_W'(i);
      end
    end
  end

  assign hijack = edgeAny && ((kind_q == K_BRK) || ((kind_q == K_HW) && (edgeIdx < src_q)));

  always_comb begin
    ack = '0;
    if ((step_q == S_5) && RDY && (kind_q == K_HW)) ack[src_q] = 1'b1;
  end

  // A new edge wins over a simultaneous acknowledge so it is never lost.
  assign pend_d = (pend_q & ~ack) | (IRQ_REQ & ~hist_q & EDGE_MASK);

  always_comb begin
    step_d = step_q;
    kind_d = kind_q;
    src_d  = src_q;
    b_d    = b_q;
    if (resPend_q) begin
      step_d = S_1;
      kind_d = K_RES;
      src_d  = '0;
      b_d    = 1'b0;
    end else if (RDY) begin
      case (step_q)
        S_IDLE: begin
          if (T0) begin
            if (reqAny) begin
              step_d = S_1;
              kind_d = K_HW;
              src_d  = reqIdx;
              b_d    = 1'b0;
            end else if (BRK_OP) begin
              step_d = S_1;
              kind_d = K_BRK;
              src_d  = '0;
              b_d    = 1'b1;
            end
          end
        end
        S_1:     step_d = S_2;
        S_2:     step_d = S_3;
        S_3:     step_d = S_4;
        S_4:     step_d = S_5;
        S_5:     step_d = S_6;
        S_6:     step_d = S_IDLE;
        default: step_d = S_IDLE;
      endcase
      // The B bit already chosen for the P push is deliberately left alone on a hijack.
      if ((step_q inside {S_1, S_2, S_3, S_4}) && hijack) begin
        kind_d = K_HW;
        src_d  = edgeIdx;
      end
    end
  end

  always_comb begin
    case (kind_q)
      K_BRK:   vecBase = BRK_VEC;
      K_HW:    vecBase = VEC_BASE + 16'({src_q, 1'b0});
      default: vecBase = RES_VEC;
    endcase
  end

  assign active     = (step_q != S_IDLE);
  assign SEQ_ACTIVE = active;
  assign SEQ_STEP   = step_q;
  assign PUSH_EN    = (step_q inside {S_2, S_3, S_4}) && (kind_q != K_RES);
  assign B_OUT      = active & b_q;
  assign VEC_VALID  = (step_q == S_5) || (step_q == S_6);
  assign VEC_ADDR   = (step_q == S_5) ? vecBase :
                      (step_q == S_6) ? vecBase + 16'd1 : 16'h0000;
  assign SET_I      = (step_q == S_6) && RDY;
  assign SRC_ID     = active ? src_q : '0;
  assign ACK        = ack;

endmodule

// File: tb/tb_int_vector_sequencer.sv
// Self-checking bench for int_vector_sequencer: directed scenarios plus randomized arbitration
// rounds compared against a priority model derived from the source/BRK rules.
module tb_int_vector_sequencer;

  logic        CLK = 1'b0;
  logic        n_RES;
  logic        RDY;
  logic        T0;
  logic        BRK_OP;
  logic        I_FLAG;
  logic [3:0]  IRQ_REQ;
  logic        SEQ_ACTIVE;
  logic [2:0]  SEQ_STEP;
  logic        PUSH_EN;
  logic        B_OUT;
  logic [15:0] VEC_ADDR;
  logic        VEC_VALID;
  logic        SET_I;
  logic [1:0]  SRC_ID;
  logic [3:0]  ACK;

  int checks = 0;
  int errors = 0;

  int          len, ackCnt, pushCnt, setICnt;
  logic [15:0] vlo, vhi;
  logic [3:0]  ackSeen;
  logic        bAt4;
  bit          stepsOk;

  int_vector_sequencer dut (
    .CLK(CLK), .n_RES(n_RES), .RDY(RDY), .T0(T0), .BRK_OP(BRK_OP), .I_FLAG(I_FLAG),
    .IRQ_REQ(IRQ_REQ), .SEQ_ACTIVE(SEQ_ACTIVE), .SEQ_STEP(SEQ_STEP), .PUSH_EN(PUSH_EN),
    .B_OUT(B_OUT), .VEC_ADDR(VEC_ADDR), .VEC_VALID(VEC_VALID), .SET_I(SET_I),
    .SRC_ID(SRC_ID), .ACK(ACK)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Follows a running sequence until it returns to idle, recording what the core would see.
  task automatic runSeq(input bit randRdy, output int n, output logic [15:0] lo,
                        output logic [15:0] hi, output logic [3:0] acks, output int nAck,
                        output int nPush, output logic b4, output int nSetI, output bit ok);
    int prevStep;
    bit prevRdy;
    n = 0; lo = 16'h0; hi = 16'h0; acks = 4'h0; nAck = 0; nPush = 0; b4 = 1'b0;
    nSetI = 0; ok = 1'b1; prevStep = -1; prevRdy = 1'b0;
    while (SEQ_ACTIVE === 1'b1 && n < 60) begin
      if (randRdy) RDY = ($urandom_range(0, 3) != 0);
      #1;
      if (prevStep >= 0 && int'(SEQ_STEP) != (prevRdy ? prevStep + 1 : prevStep)) ok = 1'b0;
      if (SEQ_STEP == 3'd5) lo = VEC_ADDR;
      if (SEQ_STEP == 3'd6) hi = VEC_ADDR;
      if (SEQ_STEP == 3'd4) b4 = B_OUT;
      if (PUSH_EN === 1'b1 && RDY) nPush++;
      if (ACK !== 4'h0) nAck++;
      acks  = acks | ACK;
      nSetI = nSetI + int'(SET_I);
      prevStep = int'(SEQ_STEP);
      prevRdy  = RDY;
      n++;
      tick();
    end
    if (prevStep != 6 || !prevRdy) ok = 1'b0;
    RDY = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (SEQ_ACTIVE !== 1'b0 || SEQ_STEP !== 3'd0 || VEC_ADDR !== 16'h0 || ACK !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_idle got act=%b step=%0d vec=%h ack=%b want 0/0/0000/0000",
               SEQ_ACTIVE, SEQ_STEP, VEC_ADDR, ACK);
    end
    n_RES = 1'b1;
    tick();
    checks++;
    if (SEQ_STEP !== 3'd1 || PUSH_EN !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_s1 got step=%0d push=%b want 1/0", SEQ_STEP, PUSH_EN);
    end
    runSeq(1'b0, len, vlo, vhi, ackSeen, ackCnt, pushCnt, bAt4, setICnt, stepsOk);
    checks++;
    if (len !== 6 || !stepsOk) begin
      errors++;
      $display("[TB] FAIL reset_len got %0d ok=%b want 6 ok=1", len, stepsOk);
    end
    checks++;
    if (vlo !== 16'hFFFC || vhi !== 16'hFFFD) begin
      errors++;
      $display("[TB] FAIL reset_vec got %h/%h want FFFC/FFFD", vlo, vhi);
    end
    checks++;
    if (pushCnt !== 0 || setICnt !== 1 || ackCnt !== 0) begin
      errors++;
      $display("[TB] FAIL reset_ctl got push=%0d seti=%0d ack=%0d want 0/1/0",
               pushCnt, setICnt, ackCnt);
    end
  endtask

  task automatic test_level_irq();
    IRQ_REQ = 4'b0100; I_FLAG = 1'b0; T0 = 1'b1;
    tick();
    T0 = 1'b0; IRQ_REQ = 4'b0000;
    runSeq(1'b0, len, vlo, vhi, ackSeen, ackCnt, pushCnt, bAt4, setICnt, stepsOk);
    checks++;
    if (len !== 6 || !stepsOk || pushCnt !== 3 || bAt4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL level_seq got len=%0d ok=%b push=%0d b=%b want 6/1/3/0",
               len, stepsOk, pushCnt, bAt4);
    end
    checks++;
    if (vlo !== 16'hFFE4 || vhi !== 16'hFFE5 || ackSeen !== 4'b0100 || ackCnt !== 1) begin
      errors++;
      $display("[TB] FAIL level_vec got %h/%h ack=%b n=%0d want FFE4/FFE5 0100 1",
               vlo, vhi, ackSeen, ackCnt);
    end
  endtask

  task automatic test_brk_hijack();
    BRK_OP = 1'b1; T0 = 1'b1;
    tick();
    BRK_OP = 1'b0; T0 = 1'b0;
    checks++;
    if (SEQ_STEP !== 3'd1 || B_OUT !== 1'b1) begin
      errors++;
      $display("[TB] FAIL brk_start got step=%0d b=%b want 1/1", SEQ_STEP, B_OUT);
    end
    tick();
    tick();
    IRQ_REQ = 4'b0001;
    runSeq(1'b0, len, vlo, vhi, ackSeen, ackCnt, pushCnt, bAt4, setICnt, stepsOk);
    checks++;
    if (vlo !== 16'hFFE0 || vhi !== 16'hFFE1 || bAt4 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hijack_vec got %h/%h b=%b want FFE0/FFE1 b=1", vlo, vhi, bAt4);
    end
    checks++;
    if (ackSeen !== 4'b0001 || ackCnt !== 1 || !stepsOk || len !== 4) begin
      errors++;
      $display("[TB] FAIL hijack_ack got ack=%b n=%0d ok=%b len=%0d want 0001/1/1/4",
               ackSeen, ackCnt, stepsOk, len);
    end
    IRQ_REQ = 4'b0000;
    tick();
  endtask

  task automatic test_reset_held();
    n_RES = 1'b0;
    #1;
    IRQ_REQ = 4'b0001;
    tick();
    n_RES = 1'b1;
    tick();
    runSeq(1'b0, len, vlo, vhi, ackSeen, ackCnt, pushCnt, bAt4, setICnt, stepsOk);
    checks++;
    if (vlo !== 16'hFFFC || ackCnt !== 0 || len !== 6) begin
      errors++;
      $display("[TB] FAIL held_resetseq got vec=%h ack=%0d len=%0d want FFFC/0/6", vlo, ackCnt, len);
    end
    T0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (SEQ_ACTIVE !== 1'b0) begin
        errors++;
        $display("[TB] FAIL held_norequest got active=%b want 0", SEQ_ACTIVE);
      end
    end
    T0 = 1'b0; IRQ_REQ = 4'b0000;
    tick();
    IRQ_REQ = 4'b0001;
    tick();
    T0 = 1'b1;
    tick();
    T0 = 1'b0;
    runSeq(1'b0, len, vlo, vhi, ackSeen, ackCnt, pushCnt, bAt4, setICnt, stepsOk);
    checks++;
    if (vlo !== 16'hFFE0 || ackSeen !== 4'b0001 || ackCnt !== 1 || len !== 6) begin
      errors++;
      $display("[TB] FAIL held_newedge got vec=%h ack=%b n=%0d len=%0d want FFE0/0001/1/6",
               vlo, ackSeen, ackCnt, len);
    end
    T0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (SEQ_ACTIVE !== 1'b0) begin
        errors++;
        $display("[TB] FAIL held_single got active=%b want 0", SEQ_ACTIVE);
      end
    end
    T0 = 1'b0; IRQ_REQ = 4'b0000;
    tick();
  endtask

  task automatic test_rdy_stall();
    logic [2:0]  sStep;
    logic        sPush, sB;
    logic [15:0] sVec;
    logic [1:0]  sSrc;
    IRQ_REQ = 4'b0010; I_FLAG = 1'b0; T0 = 1'b1;
    tick();
    T0 = 1'b0; IRQ_REQ = 4'b0000;
    tick();
    tick();
    tick();
    RDY = 1'b0;
    #1;
    sStep = 3'd4; sPush = 1'b1; sB = 1'b0; sVec = 16'h0; sSrc = 2'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (SEQ_STEP !== sStep || PUSH_EN !== sPush || B_OUT !== sB || VEC_ADDR !== sVec ||
          SRC_ID !== sSrc || ACK !== 4'h0 || SET_I !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_frozen got step=%0d push=%b b=%b vec=%h src=%0d want 4/1/0/0000/1",
                 SEQ_STEP, PUSH_EN, B_OUT, VEC_ADDR, SRC_ID);
      end
    end
    RDY = 1'b1;
    runSeq(1'b0, len, vlo, vhi, ackSeen, ackCnt, pushCnt, bAt4, setICnt, stepsOk);
    checks++;
    if (3 + 3 + len !== 9 || vlo !== 16'hFFE2 || ackSeen !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL stall_total got clocks=%0d vec=%h ack=%b want 9/FFE2/0010",
               3 + 3 + len, vlo, ackSeen);
    end
  endtask

  task automatic test_reset_mid();
    IRQ_REQ = 4'b1000; I_FLAG = 1'b0; T0 = 1'b1;
    tick();
    T0 = 1'b0; IRQ_REQ = 4'b0000;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (SEQ_STEP !== 3'd5 || VEC_ADDR !== 16'hFFE6 || VEC_VALID !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_s5 got step=%0d vec=%h valid=%b want 5/FFE6/1",
               SEQ_STEP, VEC_ADDR, VEC_VALID);
    end
    n_RES = 1'b0;
    #1;
    checks++;
    if (SEQ_ACTIVE !== 1'b0 || SEQ_STEP !== 3'd0 || VEC_ADDR !== 16'h0 ||
        VEC_VALID !== 1'b0 || ACK !== 4'h0) begin
      errors++;
      $display("[TB] FAIL mid_async got act=%b step=%0d vec=%h valid=%b ack=%b want all 0",
               SEQ_ACTIVE, SEQ_STEP, VEC_ADDR, VEC_VALID, ACK);
    end
    tick();
    n_RES = 1'b1;
    tick();
    runSeq(1'b0, len, vlo, vhi, ackSeen, ackCnt, pushCnt, bAt4, setICnt, stepsOk);
    checks++;
    if (vlo !== 16'hFFFC || vhi !== 16'hFFFD || pushCnt !== 0 || len !== 6) begin
      errors++;
      $display("[TB] FAIL mid_resetseq got %h/%h push=%0d len=%0d want FFFC/FFFD/0/6",
               vlo, vhi, pushCnt, len);
    end
  endtask

  task automatic test_random();
    logic [3:0]  pattern;
    logic [3:0]  edgeBits;
    logic        iflag, brk;
    int          winner;
    logic [15:0] expVec;
    logic [3:0]  expAck;
    edgeBits = 4'b0001;
    for (int r = 0; r < 24; r++) begin
      IRQ_REQ = 4'h0; T0 = 1'b0; BRK_OP = 1'b0; RDY = 1'b1;
      tick();
      pattern = 4'($urandom);
      iflag   = 1'($urandom);
      brk     = 1'($urandom);
      I_FLAG  = iflag;
      IRQ_REQ = pattern;
      tick();
      T0 = 1'b1; BRK_OP = brk;
      tick();
      T0 = 1'b0; BRK_OP = 1'b0;
      winner = -1;
      for (int i = 0; i < 4; i++)
        if (winner < 0 && pattern[i] && (edgeBits[i] || !iflag)) winner = i;
      if (winner < 0 && !brk) begin
        checks++;
        if (SEQ_ACTIVE !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rand_idle round=%0d got active=%b want 0", r, SEQ_ACTIVE);
        end
      end else begin
        expVec = (winner >= 0) ? 16'hFFE0 + 16'(2 * winner) : 16'hFFFE;
        expAck = (winner >= 0) ? 4'(1 << winner) : 4'h0;
        runSeq(1'b1, len, vlo, vhi, ackSeen, ackCnt, pushCnt, bAt4, setICnt, stepsOk);
        checks++;
        if (vlo !== expVec || vhi !== expVec + 16'd1 || ackSeen !== expAck ||
            bAt4 !== (winner < 0) || pushCnt !== 3 || setICnt !== 1 || !stepsOk || len >= 60) begin
          errors++;
          $display("[TB] FAIL rand_seq round=%0d got vec=%h/%h ack=%b b=%b push=%0d seti=%0d ok=%b len=%0d want %h ack=%b b=%b",
                   r, vlo, vhi, ackSeen, bAt4, pushCnt, setICnt, stepsOk, len,
                   expVec, expAck, (winner < 0));
        end
      end
    end
    IRQ_REQ = 4'h0; I_FLAG = 1'b0;
  endtask

  initial begin
    n_RES = 1'b0; RDY = 1'b1; T0 = 1'b0; BRK_OP = 1'b0; I_FLAG = 1'b0; IRQ_REQ = 4'h0;
    test_reset();
    test_level_irq();
    test_brk_hijack();
    test_reset_held();
    test_rdy_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
